// File: rtl/diffusion_unit.sv
// Pixel diffusion stage: buffers extracted key triples in a small FIFO and
// XOR-chains each incoming 24-bit pixel with one key word and the previous
// cipher block (CBC-style). One pixel per cycle when keys are available.
module diffusion_unit #(
    parameter int NUM_PIXELS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_extract,
    input  logic [22:0] ex1,
    input  logic [22:0] ex2,
    input  logic [22:0] ex3,
    output logic        key_ready,
    input  logic        start,
    input  logic [23:0] iv,
    input  logic        enc_dec,
    input  logic        pix_valid,
    input  logic [23:0] pix_in,
    output logic        pix_ready,
    output logic        out_valid,
    output logic [23:0] pix_out,
    input  logic        out_ready,
    output logic        done,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [15:0]  LAST_PIX = 16'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Only mantissa bits [15:0] feed the key word; the upper bits are dropped.
    logic unused_ex_bits;
    assign unused_ex_bits = ^{ex1[22:16], ex2[22:16], ex3[22:16]};

    // Fold each mantissa's two low bytes into one key byte.
    function automatic logic [23:0] mk_key(input logic [22:0] a,
                                           input logic [22:0] b,
                                           input logic [22:0] c);
        return {a[15:8] ^ a[7:0], b[15:8] ^ b[7:0], c[15:8] ^ c[7:0]};
    endfunction

    // The key word is formed at push time, so the FIFO stores 24-bit words.
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty, push, pop, accept;
    logic [23:0]   key_head, cipher_word;

    state_t        state_q;
    logic [23:0]   chain_q;
    logic          enc_q;
    logic [15:0]   pix_cnt_q;
    logic          out_valid_q, done_q, overflow_q;
    logic [23:0]   pix_out_q;

    // Handshake and datapath decode.
    always_comb begin
        fifo_full   = (count_q == DEPTH_C);
        fifo_empty  = (count_q == '0);
        push        = valid_extract & ~fifo_full;
        pix_ready   = (state_q == RUN) & ~fifo_empty & (~out_valid_q | out_ready);
        accept      = pix_valid & pix_ready;
        pop         = accept;
        key_head    = fifo_mem[rd_ptr_q];
        cipher_word = pix_in ^ key_head ^ chain_q;
        key_ready   = ~fifo_full;
    end

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Key storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mk_key(ex1, ex2, ex3);
        end
    end

    // FIFO pointers, occupancy and sticky overflow on a push into a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (valid_extract && fifo_full) overflow_q <= 1'b1;
        end
    end

    // Image sequencing FSM with chain register, pixel counter and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            chain_q   <= '0;
            enc_q     <= 1'b0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        chain_q   <= iv;
                        enc_q     <= enc_dec;
                        pix_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // Encrypt chains on ciphertext out, decrypt on ciphertext in.
                        chain_q   <= enc_q ? cipher_word : pix_in;
                        pix_cnt_q <= pix_cnt_q + 16'd1;
                        if (pix_cnt_q == LAST_PIX) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register: load on accept, hold under backpressure, clear when taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            pix_out_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pix_out_q   <= cipher_word;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign pix_out   = pix_out_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/diffusion_unit.md
DIFFUSION_UNIT -- requirements
Module: diffusion_unit

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 16, meaning pixels per image (1..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning key-triple FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port valid_extract  input  1  key-triple strobe from the extractor stage.
REQ-006 The block SHALL have ports ex1, ex2, ex3  input  23 each  extracted mantissas.
REQ-007 The block SHALL have port key_ready  output  1  high when the FIFO is not full.
REQ-008 The block SHALL have ports start  input  1  one-cycle image start; iv  input  24  chaining seed; enc_dec  input  1  1=encrypt, 0=decrypt.
REQ-009 The block SHALL have ports pix_valid  input  1; pix_in  input  24  {R,G,B}, R in [23:16]; pix_ready  output  1.
REQ-010 The block SHALL have ports out_valid  output  1; pix_out  output  24; out_ready  input  1; done  output  1; overflow  output  1.

Function
REQ-011 Key FIFO: valid_extract=1 with FIFO not full SHALL push {ex1,ex2,ex3}; push while full SHALL be dropped and set sticky overflow, even if a pop occurs in the same cycle.
REQ-012 Key word from a popped triple SHALL be {ex1[15:8]^ex1[7:0], ex2[15:8]^ex2[7:0], ex3[15:8]^ex3[7:0]}.
REQ-013 States SHALL be IDLE, RUN, DRAIN.
REQ-014 IDLE: start=1 SHALL load chain register with iv, latch enc_dec, clear pixel counter, and enter RUN; start in RUN/DRAIN SHALL be ignored.
REQ-015 RUN: pix_ready SHALL equal FIFO non-empty AND (out_valid=0 OR out_ready=1); pix_ready SHALL be 0 in IDLE and DRAIN.
REQ-016 Pixel accept (pix_valid & pix_ready) SHALL pop one key word k and register pix_out on the next edge with out_valid=1.
REQ-017 Encrypt: pix_out = pix_in ^ k ^ chain; chain <= pix_out.
REQ-018 Decrypt: pix_out = pix_in ^ k ^ chain; chain <= pix_in.
REQ-019 Latency SHALL be 1 cycle accept-to-out_valid; full throughput of 1 pixel/cycle when FIFO non-empty and out_ready=1.
REQ-020 out_valid and pix_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Pixel counter SHALL be 16 bits; accept of pixel NUM_PIXELS-1 SHALL move RUN -> DRAIN.
REQ-022 DRAIN: when the final output is accepted (out_valid & out_ready), done SHALL pulse 1 cycle and the state SHALL return to IDLE.
REQ-023 FIFO contents SHALL persist across images (not cleared by start); pushes SHALL be accepted in every state.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, empty the FIFO, and set key_ready=1, pix_ready=0, out_valid=0, pix_out=0, done=0, overflow=0, chain=0, counter=0.
REQ-026 Reset mid-image SHALL discard the in-flight output and all remaining keys; no done pulse.

Verification
REQ-027 Key derivation: push ex1=23'h6419F7, ex2=23'h1622C7, ex3=23'h09189F; start with iv=0, enc_dec=1; pix_in=24'h000000 -> pix_out=24'hEEE587 one cycle after accept.
REQ-028 Chaining: same key pushed twice, iv=0, encrypt pixels 0,0 -> outputs EEE587 then 000000; decrypt those with iv=0 -> 000000, 000000.
REQ-029 Backpressure: out_ready=0 for 5 cycles -> pix_out held, pix_ready=0; the next pixel is accepted in the same cycle out_ready rises.
REQ-030 FIFO: 5 pushes with no pops (depth 4) -> key_ready=0 after the 4th, overflow=1 after the 5th, occupancy 4.
REQ-031 Completion: NUM_PIXELS=16, keys fed continuously, out_ready=1 -> 16 outputs on consecutive cycles, done is a single pulse after the 16th, and start pulses while busy are ignored.
REQ-032 Reset: assert reset_n=0 after 3 pixels accepted -> all outputs at reset values within the same cycle; a new start runs a full image correctly.
